countdown_matrix_ctrl: RTL
==========================

Name: countdown_matrix_ctrl

Overview:
- Parametrised scan and count controller for the dot-matrix countdown display.
- Generates the row-scan index and a run/pause/done counter over a configurable digit range, counting up or down.
- Gates the externally supplied column pattern, including blink-on-done blanking.
- Sits between the pattern ROM modules (addressed by digit and row_bin) and the matrix connector assigns in the top level; digit also feeds the seven-segment and LED decoders.

Parameters:
ROWS, 16, number of matrix rows scanned
ROW_W, 4, width of row_bin; must satisfy 2^ROW_W >= ROWS
COLS, 16, column pattern width
CNT_DIV, 33554432, clk cycles per count tick
SCAN_DIV, 65536, clk cycles per row advance
BLINK_DIV, 8388608, clk cycles per blink half-period in DONE
HI, 9, upper digit bound (0..15)
LO, 4, lower digit bound (0..15, LO < HI)

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  synchronous reset, active-high
start  input  1  level, sampled each cycle; starts or restarts counting
pause  input  1  level; freezes counting while high in RUN
dir  input  1  0 = count down HI->LO, 1 = count up LO->HI; sampled only when start is accepted
load  input  1  synchronous load of load_val
load_val  input  4  digit to load, clamped to [LO,HI]
col_ptn  input  COLS  active-high column pattern for (digit, row_bin), from external ROM
row_bin  output  ROW_W  current scanned row, registered
digit  output  4  current count value, registered
col  output  COLS  col_ptn gated by blank (combinational AND)
done  output  1  high while in DONE state
running  output  1  high while in RUN state

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, digit=HI, row_bin=0, done=0, running=0, all prescalers=0, dir_q=0, blank=0. Hence col=col_ptn after reset.
- Scan prescaler: free-runs 0..SCAN_DIV-1 in every state. On terminal count, row_bin increments and wraps ROWS-1 -> 0. Not affected by load, start or pause.
- Count prescaler:
  - Counts 0..CNT_DIV-1 only in RUN.
  - Held in PAUSE.
  - Cleared on entry to RUN from IDLE or DONE, and on load.
  - tick = terminal count in RUN.
- Priority per cycle: rst > load > start > pause > tick.
- State machine IDLE / RUN / PAUSE / DONE:
  - Any state, load=1: digit <= clamp(load_val, LO, HI); state <= IDLE; done <= 0.
  - IDLE, start=1: dir_q <= dir; state <= RUN; digit unchanged.
  - RUN, pause=1: state <= PAUSE.
  - RUN, pause=0, tick: if digit is at the end value (LO when dir_q=0, HI when dir_q=1), state <= DONE. Otherwise digit steps by -1 or +1.
  - PAUSE, pause=0: state <= RUN, prescaler resumes from its held value. start in PAUSE is ignored.
  - DONE, start=1: dir_q <= dir; digit <= (dir ? LO : HI); state <= RUN.
  - start held high in RUN has no effect.
  - Start from IDLE with digit already at the end value: DONE is entered at the first tick.
- done and running are registered and reflect the current state; both are 0 in IDLE and PAUSE.
- Blink:
  - In DONE, a blink counter runs 0..BLINK_DIV-1; blank toggles at each terminal count, starting at 0 on DONE entry.
  - Outside DONE, blank=0 and the blink counter is 0.
- col = blank ? 0 : col_ptn. There is no register in this path, so col follows row_bin/digit with the ROM's combinational delay only.
- Width rules: digit never leaves [LO,HI]. All prescaler widths are derived with $clog2 of their parameter.

Optional Feature:
- Macro: AUTO_RELOAD_EN.
- Defined: on reaching the end value at a tick in RUN, digit reloads the start value (HI down / LO up) and state stays RUN. done pulses high for exactly one cycle, DONE is never entered, and blinking never occurs.
- Undefined: behaviour as above (hold in DONE with blink).

Test Plan:
Bench parameters: CNT_DIV=4, SCAN_DIV=2, BLINK_DIV=3, HI=9, LO=4, ROWS=16.
1. Reset then idle 40 cycles -> digit=9, row_bin advances every 2 cycles and wraps 15->0 at cycle 32; done=0, running=0, col=col_ptn.
2. start=1 one cycle, dir=0 -> running=1; digit steps 9,8,7,6,5,4 every 4 cycles; 4 cycles after digit=4, done=1, running=0, digit stays 4; col toggles between col_ptn and 0 every 3 cycles.
3. Counting down at digit=7, pause=1 for 10 cycles -> digit stays 7 and row_bin keeps scanning. Release -> the next decrement occurs after exactly the remaining prescaler cycles.
4. load=1 with load_val=2 while in RUN -> digit=4 (clamped), state IDLE, done=0. load_val=12 -> digit=9. load and start in the same cycle -> load wins, stays IDLE.
5. In DONE, start=1 with dir=1 -> digit=4, then 5..9 every 4 cycles, then DONE with digit=9. rst=1 mid-count -> all outputs at reset values on the next cycle.
6. AUTO_RELOAD_EN defined, down-count -> after digit=4 plus one tick, digit=9 with done high for exactly 1 cycle; running stays 1 and col is never blanked.

Source files
------------

// File: rtl/countdown_matrix_ctrl.sv
// Row-scan, count FSM and blink gating for the dot-matrix countdown display.
// Optional AUTO_RELOAD_EN: restart the count and pulse done instead of holding in DONE.
module countdown_matrix_ctrl #(
  parameter int ROWS      = 16,
  parameter int ROW_W     = 4,
  parameter int COLS      = 16,
  parameter int CNT_DIV   = 33554432,
  parameter int SCAN_DIV  = 65536,
  parameter int BLINK_DIV = 8388608,
  parameter int HI        = 9,
  parameter int LO        = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_pause,
  input  logic             i_dir,
  input  logic             i_load,
  input  logic [3:0]       i_load_val,
  input  logic [COLS-1:0]  i_col_ptn,
  output logic [ROW_W-1:0] o_row_bin,
  output logic [3:0]       o_digit,
  output logic [COLS-1:0]  o_col,
  output logic             o_done,
  output logic             o_running
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [SW-1:0]    SCAN_TC  = SW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]    CNT_TC   = CW'(CNT_DIV - 1);
  localparam logic [BW-1:0]    BLINK_TC = BW'(BLINK_DIV - 1);
  localparam logic [ROW_W-1:0] ROW_TC   = ROW_W'(ROWS - 1);
  localparam logic [3:0]       LO_D     = 4'(LO);
  localparam logic [3:0]       HI_D     = 4'(HI);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t           r_state, w_state_nx;
  logic [3:0]       r_digit, w_digit_nx;
  logic [ROW_W-1:0] r_row, w_row_nx;
  logic [SW-1:0]    r_scan, w_scan_nx;
  logic [CW-1:0]    r_cnt, w_cnt_nx;
  logic [BW-1:0]    r_blink, w_blink_nx;
  logic             r_blank, w_blank_nx;
  logic             r_dir_q, w_dir_nx;
  logic             r_done, r_running;
  logic             w_pulse;
  logic [3:0]       w_clamp, w_end;
  logic             w_scan_tc, w_cnt_tc, w_blink_tc;

  always_comb begin
    w_scan_tc  = (r_scan == SCAN_TC);
    w_cnt_tc   = (r_cnt == CNT_TC);
    w_blink_tc = (r_blink == BLINK_TC);
    w_end      = r_dir_q ? HI_D : LO_D;
    w_clamp    = i_load_val;
    if (i_load_val < LO_D) w_clamp = LO_D;
    if (i_load_val > HI_D) w_clamp = HI_D;

    w_scan_nx = w_scan_tc ? '0 : r_scan + SW'(1);
    w_row_nx  = r_row;
    if (w_scan_tc)
      w_row_nx = (r_row == ROW_TC) ? '0 : r_row + ROW_W'(1);

    w_state_nx = r_state;
    w_digit_nx = r_digit;
    w_dir_nx   = r_dir_q;
    w_cnt_nx   = r_cnt;
    w_blink_nx = '0;
    w_blank_nx = 1'b0;
    w_pulse    = 1'b0;

    if (i_load) begin
      w_digit_nx = w_clamp;
      w_state_nx = S_IDLE;
      w_cnt_nx   = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            w_dir_nx   = i_dir;
            w_state_nx = S_RUN;
            w_cnt_nx   = '0;
          end
        end
        S_RUN: begin
          if (i_pause) begin
            w_state_nx = S_PAUSE;
          end else if (w_cnt_tc) begin
            w_cnt_nx = '0;
            if (r_digit == w_end) begin
`ifdef AUTO_RELOAD_EN
              w_digit_nx = r_dir_q ? LO_D : HI_D;
              w_pulse    = 1'b1;
`else
              w_state_nx = S_DONE;
`endif
            end else begin
              w_digit_nx = r_dir_q ? r_digit + 4'd1
                                   : r_digit - 4'd1;
            end
          end else begin
            w_cnt_nx = r_cnt + CW'(1);
          end
        end
        S_PAUSE: begin
          if (!i_pause) w_state_nx = S_RUN;
        end
        S_DONE: begin
          if (i_start) begin
            w_dir_nx   = i_dir;
            w_digit_nx = i_dir ? LO_D : HI_D;
            w_state_nx = S_RUN;
            w_cnt_nx   = '0;
          end else begin
            w_blink_nx = w_blink_tc ? '0 : r_blink + BW'(1);
            w_blank_nx = w_blink_tc ? ~r_blank : r_blank;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_digit   <= HI_D;
      r_row     <= '0;
      r_scan    <= '0;
      r_cnt     <= '0;
      r_blink   <= '0;
      r_blank   <= 1'b0;
      r_dir_q   <= 1'b0;
      r_done    <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_digit   <= w_digit_nx;
      r_row     <= w_row_nx;
      r_scan    <= w_scan_nx;
      r_cnt     <= w_cnt_nx;
      r_blink   <= w_blink_nx;
      r_blank   <= w_blank_nx;
      r_dir_q   <= w_dir_nx;
      r_done    <= (w_state_nx == S_DONE) | w_pulse;
      r_running <= (w_state_nx == S_RUN);
    end
  end

  assign o_row_bin = r_row;
  assign o_digit   = r_digit;
  assign o_done    = r_done;
  assign o_running = r_running;
  assign o_col     = r_blank ? '0 : i_col_ptn;

endmodule
